lcd_nibble_writer: RTL and testbench

- Downstream stage of the LCD command sequencer. It accepts one byte-wide LCD write (RS + 8-bit data) per valid/ready handshake.
- Runs the controller power-on init itself, then transmits each byte as two 4-bit nibbles on SF_D[11:8], high nibble first, with Spartan-3E LCD E-pulse timing and post-command settle delays.
- Write-only: LCD_RW is tied low.
- The sequencer above it (function set, entry mode, display on, clear, DDRAM address/char stream) issues commands through the handshake; it no longer needs a PAUSE code.

---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/lcd_delay_timer.sv | 28 ++
 rtl/lcd_nibble_writer.sv | 170 +++++++++++++++++
 tb/tb_lcd_nibble_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the Spartan-3E character LCD path.
// Holds the writer's state encoding, the init nibbles, the set of
// opcodes that need the long settle, and the default 50 MHz timing
// so the command sequencer and the nibble writer agree on it.
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_PWR_WAIT,
    ST_INIT_SETUP,
    ST_INIT_PULSE,
    ST_INIT_HOLD,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_HI_SETUP,
    ST_HI_PULSE,
    ST_HI_HOLD,
    ST_GAP,
    ST_LO_SETUP,
    ST_LO_PULSE,
    ST_LO_HOLD,
    ST_SETTLE
  } lcd_state_e;

  localparam logic [3:0] INIT_NIB_A = 4'h3;  // first three init writes
  localparam logic [3:0] INIT_NIB_B = 4'h2;  // switch to 4-bit mode

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;  // home with don't-care bit 0 set

  localparam int LCD_T_SETUP   = 2;
  localparam int LCD_T_PULSE   = 12;
  localparam int LCD_T_HOLD    = 1;
  localparam int LCD_T_NIB_GAP = 50;
  localparam int LCD_T_CMD     = 2000;
  localparam int LCD_T_CLEAR   = 82000;
  localparam int LCD_T_PWR     = 750000;
  localparam int LCD_T_INIT1   = 205000;
  localparam int LCD_T_INIT2   = 5000;
  localparam int LCD_CNT_W     = 20;

  // Clear and return-home instructions need the long settle time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && (d == OP_CLEAR || d == OP_HOME || d == OP_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// State duration counter.
//   load : restart at 0 (asserted on every state change)
//   len  : length in cycles of the current state (>= 1)
//   done : high in the last cycle of the state (count == len-1)
module lcd_delay_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = load ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign done = (cnt_q == len - CNT_W'(1));

endmodule

// File: rtl/lcd_nibble_writer.sv
// 4-bit LCD write engine. Performs the power-on init, then sends each
// accepted byte as high/low nibbles on SF_D with E-pulse timing and a
// post-command settle.
//   clock, reset_n       : clock, async active-low reset
//   cmd_valid/cmd_ready  : byte handshake (ready only in IDLE)
//   cmd_rs, cmd_data     : register select and byte, latched on accept
//   init_done, busy      : init complete (sticky), not IDLE
//   LCD_E/RS/RW, SF_D    : registered LCD pins (RW tied 0)
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int T_SETUP   = LCD_T_SETUP,
  parameter int T_PULSE   = LCD_T_PULSE,
  parameter int T_HOLD    = LCD_T_HOLD,
  parameter int T_NIB_GAP = LCD_T_NIB_GAP,
  parameter int T_CMD     = LCD_T_CMD,
  parameter int T_CLEAR   = LCD_T_CLEAR,
  parameter int T_PWR     = LCD_T_PWR,
  parameter int T_INIT1   = LCD_T_INIT1,
  parameter int T_INIT2   = LCD_T_INIT2,
  parameter int CNT_W     = LCD_CNT_W
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rs,
  input  logic [7:0]  cmd_data,
  output logic        init_done,
  output logic        busy,
  output logic        LCD_E,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic [11:8] SF_D
);

  lcd_state_e       state_q, state_d;
  logic [1:0]       init_idx_q, init_idx_d;
  logic             init_done_q, init_done_d;
  logic             rs_q, rs_d;
  logic [7:0]       byte_q, byte_d;
  logic             lcd_e_q, lcd_e_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [3:0]       sf_q, sf_d;
  logic [CNT_W-1:0] len;
  logic             tmr_load, tmr_done;

  lcd_delay_timer #(.CNT_W(CNT_W)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (tmr_load),
    .len     (len),
    .done    (tmr_done)
  );

  // Duration of the state currently held.
  always_comb begin
    len = CNT_W'(1);
    case (state_q)
      ST_PWR_WAIT:                                     len = CNT_W'(T_PWR);
      ST_INIT_SETUP, ST_HI_SETUP, ST_LO_SETUP:         len = CNT_W'(T_SETUP);
      ST_INIT_PULSE, ST_HI_PULSE, ST_LO_PULSE:         len = CNT_W'(T_PULSE);
      ST_INIT_HOLD,  ST_HI_HOLD,  ST_LO_HOLD:          len = CNT_W'(T_HOLD);
      ST_GAP:                                          len = CNT_W'(T_NIB_GAP);
      ST_INIT_WAIT: begin
        case (init_idx_q)
          2'd0:    len = CNT_W'(T_INIT1);
          2'd1:    len = CNT_W'(T_INIT2);
          default: len = CNT_W'(T_CMD);
        endcase
      end
      ST_SETTLE: len = is_long_cmd(rs_q, byte_q) ? CNT_W'(T_CLEAR) : CNT_W'(T_CMD);
      default:   len = CNT_W'(1);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    byte_d      = byte_q;
    case (state_q)
      ST_PWR_WAIT:   if (tmr_done) state_d = ST_INIT_SETUP;
      ST_INIT_SETUP: if (tmr_done) state_d = ST_INIT_PULSE;
      ST_INIT_PULSE: if (tmr_done) state_d = ST_INIT_HOLD;
      ST_INIT_HOLD:  if (tmr_done) state_d = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (tmr_done) begin
          if (init_idx_q == 2'd3) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            state_d    = ST_INIT_SETUP;
          end
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          rs_d    = cmd_rs;
          byte_d  = cmd_data;
          state_d = ST_HI_SETUP;
        end
      end
      ST_HI_SETUP: if (tmr_done) state_d = ST_HI_PULSE;
      ST_HI_PULSE: if (tmr_done) state_d = ST_HI_HOLD;
      ST_HI_HOLD:  if (tmr_done) state_d = ST_GAP;
      ST_GAP:      if (tmr_done) state_d = ST_LO_SETUP;
      ST_LO_SETUP: if (tmr_done) state_d = ST_LO_PULSE;
      ST_LO_PULSE: if (tmr_done) state_d = ST_LO_HOLD;
      ST_LO_HOLD:  if (tmr_done) state_d = ST_SETTLE;
      ST_SETTLE:   if (tmr_done) state_d = ST_IDLE;
      default:     state_d = ST_PWR_WAIT;
    endcase

    // Every state change restarts the count; no state re-enters itself.
    tmr_load = (state_d != state_q);

    // Pins are computed from the next state so the registered outputs
    // line up exactly with the state they belong to.
    lcd_e_d  = state_d inside {ST_INIT_PULSE, ST_HI_PULSE, ST_LO_PULSE};
    lcd_rs_d = 1'b0;
    sf_d     = 4'h0;
    case (state_d)
      ST_INIT_SETUP, ST_INIT_PULSE, ST_INIT_HOLD:
        sf_d = (init_idx_d == 2'd3) ? INIT_NIB_B : INIT_NIB_A;
      ST_HI_SETUP, ST_HI_PULSE, ST_HI_HOLD: begin
        sf_d     = byte_d[7:4];
        lcd_rs_d = rs_d;
      end
      ST_LO_SETUP, ST_LO_PULSE, ST_LO_HOLD: begin
        sf_d     = byte_d[3:0];
        lcd_rs_d = rs_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_PWR_WAIT;
      init_idx_q  <= 2'd0;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      byte_q      <= 8'h00;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      sf_q        <= 4'h0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      byte_q      <= byte_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      sf_q        <= sf_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign init_done = init_done_q;
  assign LCD_E     = lcd_e_q;
  assign LCD_RS    = lcd_rs_q;
  assign LCD_RW    = 1'b0;
  assign SF_D      = sf_q;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
module tb_lcd_nibble_writer;
  localparam int T_SETUP = 2, T_PULSE = 3, T_HOLD = 1, T_NIB_GAP = 4;
  localparam int T_CMD = 8, T_CLEAR = 30, T_PWR = 20, T_INIT1 = 10, T_INIT2 = 6;
  localparam int NIB = T_SETUP + T_PULSE + T_HOLD;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_rs = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_ready, init_done, busy, LCD_E, LCD_RS, LCD_RW;
  logic [11:8] SF_D;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int sf; int rs; int cyc; } pulse_t;
  typedef struct { bit rs; logic [7:0] data; int hi; int lo; int lat; } vec_t;
  pulse_t pq[$];

  lcd_nibble_writer #(
    .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD), .T_NIB_GAP(T_NIB_GAP),
    .T_CMD(T_CMD), .T_CLEAR(T_CLEAR), .T_PWR(T_PWR), .T_INIT1(T_INIT1),
    .T_INIT2(T_INIT2), .CNT_W(20)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data), .init_done(init_done), .busy(busy),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .SF_D(SF_D)
  );

  always #5 clock = ~clock;

  // Edge count since reset release; first edge after release is 1.
  always @(posedge clock or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: settle is long only for instruction clear/home codes.
  function automatic int model_lat(input bit rs, input logic [7:0] d);
    int settle;
    settle = (!rs && d >= 8'd1 && d <= 8'd3) ? T_CLEAR : T_CMD;
    return 2 * NIB + T_NIB_GAP + settle;
  endfunction

  // Pin monitor: logs E pulses and checks setup/hold/width/RW.
  logic       prev_e = 1'b0, prev_rs = 1'b0;
  logic [3:0] prev_sf = 4'h0;
  int last_chg = -100, last_fall = -100, rise_c = 0;
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_e = 1'b0; prev_sf = SF_D; prev_rs = LCD_RS;
      last_chg = -100; last_fall = -100;
    end else begin
      chk("lcd_rw", LCD_RW, 0);
      if (SF_D !== prev_sf || LCD_RS !== prev_rs) begin
        chk("data_change_with_e", LCD_E | prev_e, 0);
        chk("hold_after_e", int'(cyc - last_fall >= T_HOLD), 1);
        last_chg = cyc;
      end
      if (LCD_E && !prev_e) begin
        chk("setup_before_e", int'(cyc - last_chg >= T_SETUP), 1);
        pq.push_back('{sf: int'(SF_D), rs: int'(LCD_RS), cyc: cyc});
        rise_c = cyc;
      end
      if (!LCD_E && prev_e) begin
        chk("e_width", cyc - rise_c, T_PULSE);
        last_fall = cyc;
      end
      prev_e = LCD_E; prev_sf = SF_D; prev_rs = LCD_RS;
    end
  end

  task automatic wait_ready(input int bound, output int rc);
    rc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (cmd_ready) begin rc = cyc; break; end
    end
    if (rc < 0) chk("ready_timeout", 0, 1);
  endtask

  // Assert reset mid-cycle, check reset values, release on a negedge.
  task automatic do_reset(input string nm);
    reset_n = 1'b0;
    #1;
    chk({nm, " rst_e"}, LCD_E, 0);
    chk({nm, " rst_rs"}, LCD_RS, 0);
    chk({nm, " rst_sf"}, SF_D, 0);
    chk({nm, " rst_ready"}, cmd_ready, 0);
    chk({nm, " rst_init_done"}, init_done, 0);
    chk({nm, " rst_busy"}, busy, 1);
    repeat (3) @(negedge clock);
    pq.delete();
    reset_n = 1'b1;
  endtask

  task automatic check_init(input string nm);
    int rc, t;
    int waits[4];
    int rises[4];
    waits = '{T_INIT1, T_INIT2, T_CMD, T_CMD};
    t = T_PWR;
    for (int k = 0; k < 4; k++) begin
      rises[k] = t + T_SETUP;
      t += NIB + waits[k];
    end
    wait_ready(1000, rc);
    chk({nm, " ready_cycle"}, rc, t);
    chk({nm, " init_done"}, init_done, 1);
    chk({nm, " busy_idle"}, busy, 0);
    chk({nm, " pulses"}, pq.size(), 4);
    for (int k = 0; k < 4 && k < pq.size(); k++) begin
      chk({nm, " init_nib"}, pq[k].sf, (k < 3) ? 3 : 2);
      chk({nm, " init_rs"}, pq[k].rs, 0);
      chk({nm, " init_rise"}, pq[k].cyc, rises[k]);
    end
  endtask

  task automatic chk_pulses(input string nm, input int acc, input int rs, input int hi, input int lo);
    chk({nm, " pulses"}, pq.size(), 2);
    if (pq.size() >= 2) begin
      chk({nm, " hi_nib"}, pq[0].sf, hi);
      chk({nm, " lo_nib"}, pq[1].sf, lo);
      chk({nm, " hi_rs"}, pq[0].rs, rs);
      chk({nm, " lo_rs"}, pq[1].rs, rs);
      chk({nm, " hi_rise"}, pq[0].cyc - acc, T_SETUP);
      chk({nm, " lo_rise"}, pq[1].cyc - acc, NIB + T_NIB_GAP + T_SETUP);
    end
  endtask

  task automatic send(input bit rs, input logic [7:0] d, input int hi, input int lo,
                      input int lat, input string nm);
    int rc, acc;
    wait_ready(300, rc);
    pq.delete();
    cmd_rs = rs; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clock); #1;
    acc = cyc;
    cmd_valid = 1'b0; cmd_rs = ~rs; cmd_data = ~d;  // must be ignored now
    chk({nm, " ready_drop"}, cmd_ready, 0);
    chk({nm, " busy"}, busy, 1);
    wait_ready(300, rc);
    chk({nm, " latency"}, rc - acc, lat);
    chk_pulses(nm, acc, int'(rs), hi, lo);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    int rc, a1, a2;
    bit rs;
    logic [7:0] d;
    vt.push_back('{1'b1, 8'h41, 4, 1, 24});
    vt.push_back('{1'b0, 8'h01, 0, 1, 46});
    vt.push_back('{1'b0, 8'h80, 8, 0, 24});
    vt.push_back('{1'b0, 8'h02, 0, 2, 46});
    vt.push_back('{1'b0, 8'h03, 0, 3, 46});
    vt.push_back('{1'b0, 8'h04, 0, 4, 24});
    vt.push_back('{1'b1, 8'h01, 0, 1, 24});
    vt.push_back('{1'b0, 8'h00, 0, 0, 24});
    vt.push_back('{1'b1, 8'hFF, 15, 15, 24});

    #2;
    do_reset("por");
    check_init("init");

    foreach (vt[i]) send(vt[i].rs, vt[i].data, vt[i].hi, vt[i].lo, vt[i].lat, "vec");

    repeat (25) begin
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      send(rs, d, int'(d[7:4]), int'(d[3:0]), model_lat(rs, d), "rand");
    end

    // Back-to-back: valid stays high across both bytes.
    wait_ready(300, rc);
    pq.delete();
    cmd_rs = 1'b0; cmd_data = 8'h48; cmd_valid = 1'b1;
    @(posedge clock); #1;
    a1 = cyc;
    cmd_data = 8'h49;
    wait_ready(300, rc);
    chk("b2b ready_gap", rc - a1, model_lat(1'b0, 8'h48));
    @(posedge clock); #1;
    a2 = cyc;
    cmd_valid = 1'b0;
    // second handshake completes in the first cycle ready is high
    chk("b2b accept_gap", a2 - a1, model_lat(1'b0, 8'h48) + 1);
    wait_ready(300, rc);
    chk("b2b latency2", rc - a2, 24);
    chk("b2b pulses", pq.size(), 4);
    if (pq.size() >= 4) begin
      chk("b2b n0", pq[0].sf, 4); chk("b2b n1", pq[1].sf, 8);
      chk("b2b n2", pq[2].sf, 4); chk("b2b n3", pq[3].sf, 9);
    end

    // Command held valid from reset: must wait for init to finish.
    @(negedge clock); #2;
    cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h28;
    do_reset("held");
    check_init("held");
    pq.delete();
    @(posedge clock); #1;
    a1 = cyc;
    cmd_valid = 1'b0;
    chk("held accept_cycle", a1, 77);
    chk("held ready_drop", cmd_ready, 0);
    wait_ready(300, rc);
    chk("held latency", rc - a1, 24);
    chk_pulses("held", a1, 0, 2, 8);

    // Reset during the low-nibble E pulse.
    wait_ready(300, rc);
    pq.delete();
    cmd_rs = 1'b1; cmd_data = 8'h41; cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 100 && pq.size() < 2; i++) @(negedge clock);
    chk("midrst lo_pulse_seen", pq.size(), 2);
    chk("midrst e_high", LCD_E, 1);
    #2;
    do_reset("midrst");
    check_init("reinit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
